// File: rtl/mmc3_scanline_irq.sv
// mmc3_scanline_irq
// Scanline IRQ controller for the multicart's MMC3-family mappers. Rising
// edges of PPU A12 are synchronised into the m2 domain. Each edge is
// low-time filtered, then clocks an 8-bit down-counter. The counter reloads
// from a latch when it is zero or when a reload has been requested.
//
// Ports:
//   m2           CPU M2. This is the only clock; all state changes on posedge.
//   rst_n        Asynchronous active-low reset.
//   ppu_a12      PPU address bit 12. It is asynchronous to m2.
//   wr_strobe    One-cycle pulse that marks a decoded mapper write ($8000-$FFFF).
//   wr_addr      CPU A14..A13 of that write.
//   wr_a0        CPU A0 of that write.
//   wr_data      CPU data of that write.
//   irq_n        Registered IRQ request, active low.
//   irq_counter  Current counter value, for debug and readback.
//   irq_enabled  Current IRQ enable flag.
module mmc3_scanline_irq #(
  parameter int unsigned A12_LOW_MIN   = 3,
  parameter bit          NEW_STYLE_IRQ = 1'b1,
  parameter bit          ENABLE_IRQ    = 1'b1
) (
  input  logic       m2,
  input  logic       rst_n,
  input  logic       ppu_a12,
  input  logic       wr_strobe,
  input  logic [1:0] wr_addr,
  input  logic       wr_a0,
  input  logic [7:0] wr_data,
  output logic       irq_n,
  output logic [7:0] irq_counter,
  output logic       irq_enabled
);

  localparam logic [1:0] LOW_MIN = A12_LOW_MIN[1:0];

  logic       a12_s1_q, a12_s1_d;
  logic       a12_s2_q, a12_s2_d;
  logic       a12_prev_q, a12_prev_d;
  logic [1:0] low_cnt_q, low_cnt_d;
  logic [7:0] counter_q, counter_d;
  logic [7:0] latch_q, latch_d;
  logic       reload_pending_q, reload_pending_d;
  logic       irq_enabled_q, irq_enabled_d;
  logic       irq_pending_q, irq_pending_d;
  logic       irq_n_q, irq_n_d;

  logic       clk_evt;
  logic       evt_eff;
  logic       wr_c000, wr_c001, wr_e000, wr_e001;
  logic [7:0] counter_next;

  // Register write decode. Writes to $8000-$BFFF (wr_addr[1]=0) are ignored.
  always_comb begin
    wr_c000 = wr_strobe & (wr_addr == 2'b10) & ~wr_a0;
    wr_c001 = wr_strobe & (wr_addr == 2'b10) &  wr_a0;
    wr_e000 = wr_strobe & (wr_addr == 2'b11) & ~wr_a0;
    wr_e001 = wr_strobe & (wr_addr == 2'b11) &  wr_a0;
  end

  // A12 synchroniser and low-time filter.
  // low_cnt_q holds the value from before this cycle's update. A rise
  // therefore counts only if enough low cycles came before it.
  always_comb begin
    a12_s1_d   = ppu_a12;
    a12_s2_d   = a12_s1_q;
    a12_prev_d = a12_s2_q;
    low_cnt_d  = low_cnt_q;
    if (a12_s2_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q < LOW_MIN) begin
      low_cnt_d = low_cnt_q + 2'd1;
    end
    clk_evt = a12_s2_q & ~a12_prev_q & (low_cnt_q >= LOW_MIN);
  end

  // Counter, latch and IRQ state.
  // A $C001 write in the same cycle as an A12 event wins: the event is
  // dropped entirely, including any IRQ it would have raised. All other
  // writes act on top of the event result. The event always sees the
  // pre-cycle latch and enable values.
  always_comb begin
    counter_d        = counter_q;
    latch_d          = latch_q;
    reload_pending_d = reload_pending_q;
    irq_enabled_d    = irq_enabled_q;
    irq_pending_d    = irq_pending_q;
    counter_next     = counter_q;

    evt_eff = clk_evt & ~wr_c001;

    if ((counter_q == 8'd0) || reload_pending_q) begin
      counter_next = latch_q;
    end else begin
      counter_next = counter_q - 8'd1;
    end

    if (evt_eff) begin
      counter_d        = counter_next;
      reload_pending_d = 1'b0;
      if (irq_enabled_q && (counter_next == 8'd0) &&
          (NEW_STYLE_IRQ || (counter_q != 8'd0) || reload_pending_q)) begin
        irq_pending_d = 1'b1;
      end
    end

    if (wr_c000) begin
      latch_d = wr_data;
    end
    if (wr_c001) begin
      counter_d        = '0;
      reload_pending_d = 1'b1;
    end
    if (wr_e000) begin
      irq_enabled_d = 1'b0;
      irq_pending_d = 1'b0;
    end
    if (wr_e001) begin
      irq_enabled_d = 1'b1;
    end

    // The output is registered from the pending flag, so it lags by one cycle.
    irq_n_d = ~(irq_pending_q & ENABLE_IRQ);
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      a12_s1_q         <= 1'b0;
      a12_s2_q         <= 1'b0;
      a12_prev_q       <= 1'b0;
      low_cnt_q        <= '0;
      counter_q        <= '0;
      latch_q          <= '0;
      reload_pending_q <= 1'b0;
      irq_enabled_q    <= 1'b0;
      irq_pending_q    <= 1'b0;
      irq_n_q          <= 1'b1;
    end else begin
      a12_s1_q         <= a12_s1_d;
      a12_s2_q         <= a12_s2_d;
      a12_prev_q       <= a12_prev_d;
      low_cnt_q        <= low_cnt_d;
      counter_q        <= counter_d;
      latch_q          <= latch_d;
      reload_pending_q <= reload_pending_d;
      irq_enabled_q    <= irq_enabled_d;
      irq_pending_q    <= irq_pending_d;
      irq_n_q          <= irq_n_d;
    end
  end

  assign irq_n       = irq_n_q;
  assign irq_counter = counter_q;
  assign irq_enabled = irq_enabled_q;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// tb_mmc3_scanline_irq
// Directed bench for mmc3_scanline_irq. Three instances share every input:
//   [0] new-style IRQ, [1] old-style IRQ, [2] new-style with IRQ output disabled.
module tb_mmc3_scanline_irq;

  logic       m2 = 1'b0;
  logic       rst_n;
  logic       ppu_a12;
  logic       wr_strobe;
  logic [1:0] wr_addr;
  logic       wr_a0;
  logic [7:0] wr_data;

  logic       irq_n_w   [3];
  logic [7:0] cnt_w     [3];
  logic       en_w      [3];

  int checks = 0;
  int errors = 0;

  always #5 m2 = ~m2;

  mmc3_scanline_irq #(.A12_LOW_MIN(3), .NEW_STYLE_IRQ(1'b1), .ENABLE_IRQ(1'b1)) u_new (
    .m2(m2), .rst_n(rst_n), .ppu_a12(ppu_a12), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_a0(wr_a0), .wr_data(wr_data),
    .irq_n(irq_n_w[0]), .irq_counter(cnt_w[0]), .irq_enabled(en_w[0]));

  mmc3_scanline_irq #(.A12_LOW_MIN(3), .NEW_STYLE_IRQ(1'b0), .ENABLE_IRQ(1'b1)) u_old (
    .m2(m2), .rst_n(rst_n), .ppu_a12(ppu_a12), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_a0(wr_a0), .wr_data(wr_data),
    .irq_n(irq_n_w[1]), .irq_counter(cnt_w[1]), .irq_enabled(en_w[1]));

  mmc3_scanline_irq #(.A12_LOW_MIN(3), .NEW_STYLE_IRQ(1'b1), .ENABLE_IRQ(1'b0)) u_off (
    .m2(m2), .rst_n(rst_n), .ppu_a12(ppu_a12), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_a0(wr_a0), .wr_data(wr_data),
    .irq_n(irq_n_w[2]), .irq_counter(cnt_w[2]), .irq_enabled(en_w[2]));

  task automatic tick();
    @(posedge m2);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic a0, input logic [7:0] d);
    wr_strobe = 1'b1;
    wr_addr   = a;
    wr_a0     = a0;
    wr_data   = d;
    tick();
    wr_strobe = 1'b0;
    wr_addr   = 2'b00;
    wr_a0     = 1'b0;
    wr_data   = 8'h00;
  endtask

  // Drive A12 low for lo cycles, then high for hi cycles. A counted rise
  // updates the counter on the 3rd edge after the pin goes high.
  task automatic a12_pulse(input int lo, input int hi);
    ppu_a12 = 1'b0;
    repeat (lo) tick();
    ppu_a12 = 1'b1;
    repeat (hi) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt_w[i] !== 8'd0 || irq_n_w[i] !== 1'b1 || en_w[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: cnt=%0d irq_n=%b en=%b, want 0/1/0", i, cnt_w[i], irq_n_w[i], en_w[i]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_count();
    logic [7:0] exp_cnt [6] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    cpu_write(2'b10, 1'b0, 8'd5);
    cpu_write(2'b10, 1'b1, 8'd0);
    cpu_write(2'b11, 1'b1, 8'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (en_w[i] !== 1'b1) begin
        errors++;
        $display("FAIL basic_enable dut%0d: en=%b want 1", i, en_w[i]);
      end
    end
    for (int e = 0; e < 6; e++) begin
      a12_pulse(4, 3);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt_w[i] !== exp_cnt[e] || irq_n_w[i] !== 1'b1) begin
          errors++;
          $display("FAIL basic_event%0d dut%0d: cnt=%0d irq_n=%b want %0d/1", e, i, cnt_w[i], irq_n_w[i], exp_cnt[e]);
        end
      end
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (irq_n_w[i] !== (i == 2)) begin
        errors++;
        $display("FAIL basic_irq dut%0d: irq_n=%b want %b", i, irq_n_w[i], (i == 2));
      end
    end
    cpu_write(2'b11, 1'b0, 8'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (irq_n_w[i] !== 1'b1 || en_w[i] !== 1'b0) begin
        errors++;
        $display("FAIL basic_ack dut%0d: irq_n=%b en=%b want 1/0", i, irq_n_w[i], en_w[i]);
      end
    end
  endtask

  task automatic test_glitch_filter();
    logic [7:0] exp_cnt [4] = '{8'd5, 8'd5, 8'd4, 8'd4};
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: a12_pulse(4, 4);
        1: a12_pulse(2, 5);
        2: a12_pulse(3, 10);
        default: repeat (10) tick();
      endcase
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt_w[i] !== exp_cnt[s]) begin
          errors++;
          $display("FAIL filter_step%0d dut%0d: cnt=%0d want %0d", s, i, cnt_w[i], exp_cnt[s]);
        end
      end
    end
  endtask

  task automatic test_latch_zero();
    cpu_write(2'b10, 1'b0, 8'd0);
    cpu_write(2'b10, 1'b1, 8'd0);
    cpu_write(2'b11, 1'b1, 8'd0);
    for (int e = 0; e < 3; e++) begin
      a12_pulse(4, 4);
      for (int i = 0; i < 3; i++) begin
        logic want;
        want = (i == 2) ? 1'b1 : ((i == 1) ? (e != 0) : 1'b0);
        checks++;
        if (cnt_w[i] !== 8'd0 || irq_n_w[i] !== want) begin
          errors++;
          $display("FAIL latch0_event%0d dut%0d: cnt=%0d irq_n=%b want 0/%b", e, i, cnt_w[i], irq_n_w[i], want);
        end
      end
      cpu_write(2'b11, 1'b0, 8'd0);
      cpu_write(2'b11, 1'b1, 8'd0);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (irq_n_w[i] !== 1'b1) begin
          errors++;
          $display("FAIL latch0_ack%0d dut%0d: irq_n=%b want 1", e, i, irq_n_w[i]);
        end
      end
    end
  endtask

  // Drive an A12 rise so that the counted event lands on the same edge as a write.
  task automatic evt_with_write(input logic [1:0] a, input logic a0, input logic [7:0] d);
    ppu_a12 = 1'b0;
    repeat (4) tick();
    ppu_a12 = 1'b1;
    tick();
    tick();
    cpu_write(a, a0, d);
  endtask

  task automatic test_collisions();
    cpu_write(2'b11, 1'b0, 8'd0);
    cpu_write(2'b10, 1'b0, 8'd3);
    cpu_write(2'b10, 1'b1, 8'd0);
    a12_pulse(4, 4);
    cpu_write(2'b11, 1'b1, 8'd0);
    // $C001 with event: write wins.
    evt_with_write(2'b10, 1'b1, 8'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt_w[i] !== 8'd0 || irq_n_w[i] !== 1'b1) begin
        errors++;
        $display("FAIL coll_c001 dut%0d: cnt=%0d irq_n=%b want 0/1", i, cnt_w[i], irq_n_w[i]);
      end
    end
    for (int e = 0; e < 3; e++) begin
      a12_pulse(4, 4);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt_w[i] !== 8'(3 - e)) begin
          errors++;
          $display("FAIL coll_reload%0d dut%0d: cnt=%0d want %0d", e, i, cnt_w[i], 3 - e);
        end
      end
    end
    // $E000 with event reaching zero: no IRQ.
    evt_with_write(2'b11, 1'b0, 8'd0);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt_w[i] !== 8'd0 || irq_n_w[i] !== 1'b1 || en_w[i] !== 1'b0) begin
        errors++;
        $display("FAIL coll_e000 dut%0d: cnt=%0d irq_n=%b en=%b want 0/1/0", i, cnt_w[i], irq_n_w[i], en_w[i]);
      end
    end
    // $C000 with event: reload uses the old latch (3).
    evt_with_write(2'b10, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt_w[i] !== 8'd3) begin
        errors++;
        $display("FAIL coll_c000 dut%0d: cnt=%0d want 3", i, cnt_w[i]);
      end
    end
    cpu_write(2'b10, 1'b1, 8'd0);
    // $E001 with event reaching zero: the event sees enable=0.
    evt_with_write(2'b11, 1'b1, 8'd0);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt_w[i] !== 8'd0 || irq_n_w[i] !== 1'b1 || en_w[i] !== 1'b1) begin
        errors++;
        $display("FAIL coll_e001 dut%0d: cnt=%0d irq_n=%b en=%b want 0/1/1", i, cnt_w[i], irq_n_w[i], en_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    cpu_write(2'b11, 1'b0, 8'd0);
    cpu_write(2'b10, 1'b0, 8'd0);
    cpu_write(2'b10, 1'b1, 8'd0);
    cpu_write(2'b11, 1'b1, 8'd0);
    a12_pulse(4, 4);
    cpu_write(2'b10, 1'b0, 8'd7);
    a12_pulse(4, 4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt_w[i] !== 8'd7 || irq_n_w[i] !== (i == 2)) begin
        errors++;
        $display("FAIL rstmid_setup dut%0d: cnt=%0d irq_n=%b want 7/%b", i, cnt_w[i], irq_n_w[i], (i == 2));
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt_w[i] !== 8'd0 || irq_n_w[i] !== 1'b1 || en_w[i] !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_async dut%0d: cnt=%0d irq_n=%b en=%b want 0/1/0", i, cnt_w[i], irq_n_w[i], en_w[i]);
      end
    end
    ppu_a12 = 1'b0;
    repeat (3) tick();
    // Release with A12 already high: this rise has no qualifying low period.
    ppu_a12 = 1'b1;
    rst_n   = 1'b1;
    cpu_write(2'b10, 1'b0, 8'd5);
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt_w[i] !== 8'd0) begin
        errors++;
        $display("FAIL rstmid_first_rise dut%0d: cnt=%0d want 0", i, cnt_w[i]);
      end
    end
    a12_pulse(4, 4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt_w[i] !== 8'd5) begin
        errors++;
        $display("FAIL rstmid_after dut%0d: cnt=%0d want 5", i, cnt_w[i]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ppu_a12   = 1'b0;
    wr_strobe = 1'b0;
    wr_addr   = 2'b00;
    wr_a0     = 1'b0;
    wr_data   = 8'h00;
    test_reset();
    test_basic_count();
    test_glitch_filter();
    test_latch_zero();
    test_collisions();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmc3_scanline_irq.md
Name: mmc3_scanline_irq

Overview:
- Scanline IRQ controller for the multicart's MMC3-family mappers.
- Counts filtered rising edges of PPU A12 in the m2 clock domain.
- Decodes the four IRQ register writes ($C000/$C001/$E000/$E001) passed in from the mapper write decoder.
- Drives the cartridge irq line, active-low; the top level ties irq to irq_n.

Parameters:
A12_LOW_MIN, 3, m2 cycles of synchronised A12 low required before a rise counts (filters the 8x8 sprite-fetch A12 toggles).
NEW_STYLE_IRQ, 1, 1 = Sharp/"new" behaviour (IRQ whenever counter is 0 after a clock); 0 = NEC/"old" behaviour (IRQ only on a transition to 0).
ENABLE_IRQ, 1, 0 = block inert: irq_n held 1, registers still writable.

Ports:
m2  input  1  CPU M2, the only clock; all state updates on posedge m2.
rst_n  input  1  asynchronous active-low reset.
ppu_a12  input  1  PPU address bit 12, asynchronous to m2.
wr_strobe  input  1  one-cycle pulse: a CPU write to $8000-$FFFF was decoded for this mapper.
wr_addr  input  2  CPU A14..A13 of that write.
wr_a0  input  1  CPU A0 of that write.
wr_data  input  8  CPU data of that write.
irq_n  output  1  IRQ request, active low.
irq_counter  output  8  current counter value (debug/readback).
irq_enabled  output  1  current enable flag.

Behaviour:
- Reset (async, rst_n=0), all held while low:
  - counter=0, latch=0, reload_pending=0, irq_enabled=0, irq_pending=0, irq_n=1.
  - A12 synchroniser flops=0; low_cnt=0.
  - low_cnt=0 means the first A12 rise after reset is ignored unless preceded by A12_LOW_MIN low cycles.
- A12 path:
  - 2-flop synchroniser a12_s1 -> a12_s2, plus a12_prev = a12_s2 delayed 1 cycle.
  - low_cnt, 2-bit saturating:
    - increments each cycle a12_s2=0, saturates at A12_LOW_MIN;
    - cleared on the cycle a12_s2=1.
  - clk_evt = a12_s2 & ~a12_prev & (low_cnt >= A12_LOW_MIN), where low_cnt is the value before this cycle's update.
  - Latency: A12 rise on pin -> counter update ≤3 m2 edges.
- Register writes, effective on the posedge where wr_strobe=1; ignored unless wr_addr[1]=1:
  - wr_addr=2'b10, a0=0 ($C000): latch <= wr_data.
  - wr_addr=2'b10, a0=1 ($C001): counter <= 0; reload_pending <= 1.
  - wr_addr=2'b11, a0=0 ($E000): irq_enabled <= 0; irq_pending <= 0.
  - wr_addr=2'b11, a0=1 ($E001): irq_enabled <= 1.
  - wr_addr=2'b0x: no effect.
- Counter clocking, on clk_evt:
  - If counter==0 or reload_pending: next = latch, reload_pending <= 0.
  - Else: next = counter-1 (8-bit; never wraps, since 0 always reloads).
  - IRQ set, using the pre-cycle irq_enabled value:
    - NEW_STYLE_IRQ=1: irq_pending <= 1 if next==0 and irq_enabled.
    - NEW_STYLE_IRQ=0: irq_pending <= 1 if next==0 and irq_enabled and (counter!=0 or reload_pending).
- irq_pending is sticky until $E000 or reset. irq_n = ~(irq_pending & ENABLE_IRQ), registered, so it asserts 1 cycle after the clk_evt edge.
- Simultaneous events in one cycle:
  - $C001 + clk_evt: the write wins. Counter=0, reload_pending=1, the event is discarded, no IRQ set.
  - $C000 + clk_evt: a reload in this cycle uses the old latch; the new latch applies from the next cycle.
  - $E000 + clk_evt: pending is cleared and stays cleared this cycle.
  - $E001 + clk_evt: the event sees the old enable (0), so no IRQ this cycle.
- Latch=0 case:
  - NEW_STYLE_IRQ=1: IRQ on every counted event.
  - NEW_STYLE_IRQ=0: IRQ only on the first event after a $C001 write.
- Reset mid-operation: all state returns to reset values immediately; an asserted irq_n releases asynchronously.

Test Plan:
1. Reset, $C000=5, $C001, $E001, then 6 filtered A12 rises (each preceded by ≥3 low cycles). Required: counter sequence 5,4,3,2,1,0; irq_n=0 one cycle after the 6th event; $E000 -> irq_n=1 next cycle, irq_enabled=0.
2. A12 glitch filter. A12 low 2 cycles then high -> no counter change. Low 3 cycles then high -> exactly one decrement. A12 held high 10 cycles -> one event only.
3. Latch=0, $C001, $E001, 3 events:
   - NEW_STYLE_IRQ=1: irq set on every event, re-set after each $E000/$E001.
   - NEW_STYLE_IRQ=0: irq only on the 1st event.
4. Collisions, counter=3:
   - $C001 on the clk_evt cycle: counter=0, reload_pending=1, next event loads the latch.
   - $E000 with clk_evt reaching 0: irq_n stays 1.
5. rst_n pulsed low while irq_n=0, counter=7. Required: irq_n=1 asynchronously, counter=0, latch=0; the first A12 rise after release without a low period is ignored.
6. ENABLE_IRQ=0, scenario 1 stimulus: counter sequence identical; irq_n stays 1 throughout.
